// File: rtl/pc_gen_pkg.sv
// Shared types and constants for the program-counter generator.
// FSM state encoding, redirect source indices and default reset vector.
package pc_gen_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  localparam int REDIR_EXC = 0;
  localparam int REDIR_JMP = 1;
  localparam int REDIR_BR  = 2;

  localparam int          DEF_XLEN        = 32;
  localparam int          DEF_NUM_REDIR   = 3;
  localparam int          DEF_INSTR_BYTES = 4;
  localparam logic [31:0] DEF_RESET_VEC   = 32'h0000_0000;

  function automatic logic is_aligned(input logic [1:0] lsb);
    return (lsb == 2'b00);
  endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Redirect and instruction-fetch bundle between pc_gen and its neighbours.
// master = pc_gen side; slave = decode/trap + instruction memory side.
interface pc_gen_if #(
  parameter int XLEN      = 32,
  parameter int NUM_REDIR = 3
);
  logic [NUM_REDIR-1:0]      redir_valid;
  logic [NUM_REDIR*XLEN-1:0] redir_addr;
  logic [NUM_REDIR-1:0]      redir_taken;
  logic                      fetch_valid;
  logic                      fetch_ready;
  logic [XLEN-1:0]           fetch_addr;

  modport master (
    input  redir_valid, redir_addr, fetch_ready,
    output redir_taken, fetch_valid, fetch_addr
  );

  modport slave (
    output redir_valid, redir_addr, fetch_ready,
    input  redir_taken, fetch_valid, fetch_addr
  );
endinterface

// File: rtl/pc_gen_prio_arb.sv
// Fixed-priority arbiter: lowest set request index wins.
// Produces a one-hot grant, the encoded winner index and an any-request flag.
module prio_arb #(
  parameter int N    = 3,
  parameter int IDXW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    i_req,
  output logic [N-1:0]    o_gnt,
  output logic [IDXW-1:0] o_idx,
  output logic            o_any
);

  // Scan high to low so the last hit (lowest index) is the one that sticks.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_gnt    = '0;
        o_gnt[i] = 1'b1;
        o_idx    = IDXW'(i);
        o_any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Registered program counter with prioritised redirects, fetch handshake, stall and halt.
// Optional PC_GEN_MISALIGN_CHK_EN rejects redirect targets that are not word aligned.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int              XLEN        = DEF_XLEN,
  parameter int              NUM_REDIR   = DEF_NUM_REDIR,
  parameter logic [XLEN-1:0] RESET_VEC   = DEF_RESET_VEC,
  parameter int              INSTR_BYTES = DEF_INSTR_BYTES
) (
  input  logic      clk,
  input  logic      rst_n,
  pc_gen_if.master  bus,
  input  logic      i_stall,
  input  logic      i_halt_req,
  input  logic      i_resume,
  output logic      o_halted
`ifdef PC_GEN_MISALIGN_CHK_EN
  ,
  output logic      o_misalign_err
`endif
);

  localparam int IDXW = (NUM_REDIR > 1) ? $clog2(NUM_REDIR) : 1;

  state_e          r_state, w_state_nxt;
  logic [XLEN-1:0] r_pc, w_pc_nxt;
  logic            r_halt_pend, w_halt_pend_nxt;

  logic [NUM_REDIR-1:0][XLEN-1:0] w_tgt;
  logic [NUM_REDIR-1:0]           w_gnt;
  logic [IDXW-1:0]                w_idx;
  logic                           w_any;
  logic [XLEN-1:0]                w_sel_addr;
  logic                           w_misalign;
  logic                           w_apply;
  logic                           w_fetch_vld;
  logic                           w_fire;

  prio_arb #(.N(NUM_REDIR), .IDXW(IDXW)) u_arb (
    .i_req (bus.redir_valid),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  // Packed view of the flat bus: element i is bits [i*XLEN +: XLEN].
  assign w_tgt      = bus.redir_addr;
  assign w_sel_addr = w_tgt[w_idx];

`ifdef PC_GEN_MISALIGN_CHK_EN
  logic r_misalign_err;
  assign w_misalign     = w_any && !is_aligned(w_sel_addr[1:0]);
  assign o_misalign_err = r_misalign_err;
`else
  assign w_misalign = 1'b0;
`endif

  assign w_apply     = w_any && !w_misalign;
  assign w_fetch_vld = (r_state == ST_RUN) && !i_stall;
  assign w_fire      = w_fetch_vld && bus.fetch_ready;

  assign bus.fetch_valid = w_fetch_vld;
  assign bus.fetch_addr  = r_pc;
  assign bus.redir_taken = w_apply ? w_gnt : '0;
  assign o_halted        = (r_state == ST_HALT);

  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_halt_pend_nxt = r_halt_pend;

    // A redirect wins over stall and drops any unaccepted fetch.
    if (w_apply)
      w_pc_nxt = w_sel_addr;
    else if (w_fire)
      w_pc_nxt = r_pc + XLEN'(INSTR_BYTES);

    case (r_state)
      ST_BOOT: begin
        w_state_nxt     = ST_RUN;
        w_halt_pend_nxt = 1'b0;
      end
      ST_RUN: begin
        // Halt waits for an outstanding fetch unless a redirect just dropped it.
        if (i_halt_req || r_halt_pend) begin
          if (w_fetch_vld && !bus.fetch_ready && !w_apply) begin
            w_halt_pend_nxt = 1'b1;
          end else begin
            w_state_nxt     = ST_HALT;
            w_halt_pend_nxt = 1'b0;
          end
        end
      end
      ST_HALT: begin
        w_halt_pend_nxt = 1'b0;
        if (i_resume)
          w_state_nxt = ST_RUN;
      end
      default: begin
        w_state_nxt     = ST_BOOT;
        w_halt_pend_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_BOOT;
      r_pc        <= RESET_VEC;
      r_halt_pend <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_halt_pend <= w_halt_pend_nxt;
    end
  end

`ifdef PC_GEN_MISALIGN_CHK_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      r_misalign_err <= 1'b0;
    else
      r_misalign_err <= w_any && w_misalign;
  end
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: accepted fetch addresses are checked against a scoreboard queue.
// Covers reset, sequencing, backpressure, redirect priority, halt/resume, wrap, mid-op reset.
module tb_pc_gen;

  logic clk = 1'b0;
  logic rst_n;
  logic stall, halt_req, resume, halted;
`ifdef PC_GEN_MISALIGN_CHK_EN
  logic misalign_err;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  pc_gen_if #(.XLEN(32), .NUM_REDIR(3)) bus ();

  pc_gen #(.XLEN(32), .NUM_REDIR(3), .RESET_VEC(32'h0), .INSTR_BYTES(4)) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .i_stall        (stall),
    .i_halt_req     (halt_req),
    .i_resume       (resume),
    .o_halted       (halted)
`ifdef PC_GEN_MISALIGN_CHK_EN
    ,
    .o_misalign_err (misalign_err)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Handshake completes at the coming edge when valid&&ready with no redirect present.
  task automatic sb();
    if (bus.fetch_valid === 1'b1 && bus.fetch_ready === 1'b1 && bus.redir_valid == 3'b000) begin
      n_assert++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL sb_unexpected: observed fetch %h expected none", bus.fetch_addr);
      end
      if (exp_q.size() != 0) chk("sb_fetch", bus.fetch_addr, exp_q.pop_front());
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
    sb();
  endtask

  task automatic redir(input logic [2:0] v, input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] a2);
    bus.redir_valid = v;
    bus.redir_addr  = {a2, a1, a0};
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; halt_req = 1'b0; resume = 1'b0;
    bus.fetch_ready = 1'b1;
    redir(3'b000, 32'h0, 32'h0, 32'h0);

    // Reset
    nxt(); nxt(); settle();
    chk("rst_fetch_valid", {31'b0, bus.fetch_valid}, 32'd0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    chk("rst_taken", {29'b0, bus.redir_taken}, 32'd0);
    chk("rst_pc", bus.fetch_addr, 32'h0);

    // BOOT cycle, then sequential fetch
    nxt(); rst_n = 1'b1; settle();
    chk("boot_fetch_valid", {31'b0, bus.fetch_valid}, 32'd0);
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    exp_q.push_back(32'h8); exp_q.push_back(32'hC);
    repeat (4) begin nxt(); settle(); end

    // Backpressure at 0x10
    for (int i = 0; i < 3; i++) begin
      nxt(); bus.fetch_ready = 1'b0; settle();
      chk("bp_valid", {31'b0, bus.fetch_valid}, 32'd1);
      chk("bp_addr", bus.fetch_addr, 32'h10);
    end
    nxt(); bus.fetch_ready = 1'b1; exp_q.push_back(32'h10); settle();
    nxt(); exp_q.push_back(32'h14); settle();
    chk("bp_next", bus.fetch_addr, 32'h14);

    // Simultaneous redirects under stall
    nxt(); stall = 1'b1; redir(3'b110, 32'h0, 32'h200, 32'h300); settle();
    chk("redir_jmp_taken", {29'b0, bus.redir_taken}, 32'b010);
    chk("stall_valid", {31'b0, bus.fetch_valid}, 32'd0);
    nxt(); redir(3'b111, 32'h80, 32'h200, 32'h300); settle();
    chk("redir_jmp_pc", bus.fetch_addr, 32'h200);
    chk("redir_exc_taken", {29'b0, bus.redir_taken}, 32'b001);
    nxt(); stall = 1'b0; redir(3'b000, 32'h0, 32'h0, 32'h0); exp_q.push_back(32'h80); settle();
    chk("redir_exc_pc", bus.fetch_addr, 32'h80);

    // Halt while a fetch is waiting for ready
    nxt(); bus.fetch_ready = 1'b0; redir(3'b001, 32'h40, 32'h0, 32'h0); settle();
    nxt(); redir(3'b000, 32'h0, 32'h0, 32'h0); halt_req = 1'b1; settle();
    chk("halt_wait_addr", bus.fetch_addr, 32'h40);
    nxt(); halt_req = 1'b0; settle();
    chk("halt_wait_halted", {31'b0, halted}, 32'd0);
    chk("halt_wait_valid", {31'b0, bus.fetch_valid}, 32'd1);
    nxt(); bus.fetch_ready = 1'b1; exp_q.push_back(32'h40); settle();
    nxt(); settle();
    chk("halted", {31'b0, halted}, 32'd1);
    chk("halted_valid", {31'b0, bus.fetch_valid}, 32'd0);
    chk("halted_pc", bus.fetch_addr, 32'h44);

    // Redirect while halted, then resume
    nxt(); redir(3'b010, 32'h0, 32'h100, 32'h0); settle();
    chk("halt_redir_taken", {29'b0, bus.redir_taken}, 32'b010);
    nxt(); redir(3'b000, 32'h0, 32'h0, 32'h0); settle();
    chk("halt_redir_still", {31'b0, halted}, 32'd1);
    chk("halt_redir_pc", bus.fetch_addr, 32'h100);
    nxt(); resume = 1'b1; halt_req = 1'b1; settle();
    chk("resume_cycle_halted", {31'b0, halted}, 32'd1);
    nxt(); resume = 1'b0; halt_req = 1'b0; exp_q.push_back(32'h100); settle();
    chk("resumed", {31'b0, halted}, 32'd0);

    // Wrap at top of address space
    nxt(); bus.fetch_ready = 1'b0; redir(3'b100, 32'h0, 32'h0, 32'hFFFF_FFFC); settle();
    chk("wrap_taken", {29'b0, bus.redir_taken}, 32'b100);
    nxt(); redir(3'b000, 32'h0, 32'h0, 32'h0); bus.fetch_ready = 1'b1;
    exp_q.push_back(32'hFFFF_FFFC); settle();
    nxt(); exp_q.push_back(32'h0); settle();
    chk("wrap_addr", bus.fetch_addr, 32'h0);

    // Mid-operation reset with a pending fetch
    nxt(); bus.fetch_ready = 1'b0; settle();
    chk("pend_addr", bus.fetch_addr, 32'h4);
    nxt(); rst_n = 1'b0; settle();
    nxt(); settle();
    chk("midrst_valid", {31'b0, bus.fetch_valid}, 32'd0);
    chk("midrst_pc", bus.fetch_addr, 32'h0);
    nxt(); rst_n = 1'b1; settle();
    chk("midrst_boot", {31'b0, bus.fetch_valid}, 32'd0);
    nxt(); bus.fetch_ready = 1'b1; exp_q.push_back(32'h0); settle();

    // Jump to a misaligned target
    nxt(); bus.fetch_ready = 1'b0; redir(3'b010, 32'h0, 32'h202, 32'h0); settle();
`ifdef PC_GEN_MISALIGN_CHK_EN
    chk("mis_taken", {29'b0, bus.redir_taken}, 32'b000);
    chk("mis_err_early", {31'b0, misalign_err}, 32'd0);
    nxt(); redir(3'b000, 32'h0, 32'h0, 32'h0); settle();
    chk("mis_err", {31'b0, misalign_err}, 32'd1);
    chk("mis_pc", bus.fetch_addr, 32'h4);
    nxt(); settle();
    chk("mis_err_pulse", {31'b0, misalign_err}, 32'd0);
`else
    chk("unchk_taken", {29'b0, bus.redir_taken}, 32'b010);
    nxt(); redir(3'b000, 32'h0, 32'h0, 32'h0); settle();
    chk("unchk_pc", bus.fetch_addr, 32'h202);
`endif

    chk("sb_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
